// File: rtl/test_end_monitor.sv
// rtl/test_end_monitor.sv - synthesizable end-of-test monitor (pass/fail/timeout)
//
// Purpose:
//   Watches core probe signals and counts RUN cycles, retired (valid)
//   instructions and retirements of the tohost PC. When the hit count
//   reaches HIT_THRESHOLD the result register is captured and the test
//   ends in PASS or FAIL. An optional cycle limit ends it in TMO.
//   All outputs are registered.
//
// Ports:
//   clk          in   core clock
//   cpurst_n     in   asynchronous active-low reset
//   mon_en       in   arm (IDLE->RUN) / run enable (low pauses RUN)
//   mon_clr      in   synchronous clear back to IDLE, highest priority
//   inst_valid   in   instruction valid into execute
//   inst_pc      in   PC of that instruction
//   result_val   in   result register value
//   done         out  test finished (pass | fail | timeout)
//   pass         out  finished with result == PASS_VALUE
//   fail         out  finished with result != PASS_VALUE
//   timeout      out  cycle limit reached before the hit threshold
//   cycle_cnt    out  RUN cycles counted
//   instret_cnt  out  valid instructions counted
//   hit_cnt      out  tohost hits counted
//   result_cap   out  result_val sampled when the test ended
//   mon_state    out  FSM state encoding

module test_end_monitor #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] TOHOST_PC      = 32'h00000086,
  parameter int unsigned HIT_THRESHOLD  = 8,
  parameter logic [31:0] PASS_VALUE     = 32'd1,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             cpurst_n,
  input  logic             mon_en,
  input  logic             mon_clr,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  inst_pc,
  input  logic [XLEN-1:0]  result_val,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [XLEN-1:0]  result_cap,
  output logic [2:0]       mon_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd1;
  localparam logic [2:0] ST_PASS = 3'd2;
  localparam logic [2:0] ST_FAIL = 3'd3;
  localparam logic [2:0] ST_TMO  = 3'd4;

  // Compare constants resized to the datapath widths (truncate or zero-extend).
  localparam logic [XLEN-1:0]  TOHOST_X = XLEN'(TOHOST_PC);
  localparam logic [XLEN-1:0]  PASS_X   = XLEN'(PASS_VALUE);
  localparam logic [CNT_W-1:0] HIT_THR  = CNT_W'(HIT_THRESHOLD);
  localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [XLEN-1:0]  cap_q, cap_d;
  logic             done_q, pass_q, fail_q, tmo_q;

  logic             is_hit;
  logic [CNT_W-1:0] cycle_inc, instret_inc, hit_inc;
  logic             cycle_sat, instret_sat, hit_sat;
  logic             final_hit, tmo_reach;

  assign is_hit      = inst_valid && (inst_pc == TOHOST_X);

  assign cycle_sat   = (cycle_q == CNT_MAX);
  assign instret_sat = (instret_q == CNT_MAX);
  assign hit_sat     = (hit_q == CNT_MAX);

  assign cycle_inc   = cycle_q + CNT_W'(1);
  assign instret_inc = instret_q + CNT_W'(1);
  assign hit_inc     = hit_q + CNT_W'(1);

  // A saturated counter no longer increments, so it can never newly
  // reach the threshold/limit; the test then ends only by timeout or clear.
  assign final_hit = is_hit && !hit_sat && (hit_inc == HIT_THR);
  assign tmo_reach = TMO_EN && !cycle_sat && (cycle_inc == TMO_LIM);

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    hit_d     = hit_q;
    cap_d     = cap_q;

    if (mon_clr) begin
      state_d   = ST_IDLE;
      cycle_d   = '0;
      instret_d = '0;
      hit_d     = '0;
      cap_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mon_en) begin
            state_d = ST_RUN;
          end
        end

        ST_RUN: begin
          // mon_en low pauses: everything holds, state stays RUN.
          if (mon_en) begin
            if (!cycle_sat) begin
              cycle_d = cycle_inc;
            end
            if (inst_valid && !instret_sat) begin
              instret_d = instret_inc;
            end
            if (is_hit && !hit_sat) begin
              hit_d = hit_inc;
            end
            // Final hit is checked first so it wins over a same-edge timeout.
            if (final_hit) begin
              cap_d   = result_val;
              state_d = (result_val == PASS_X) ? ST_PASS : ST_FAIL;
            end else if (tmo_reach) begin
              cap_d   = result_val;
              state_d = ST_TMO;
            end
          end
        end

        ST_PASS, ST_FAIL, ST_TMO: begin
          // Terminal: counters and capture frozen until clear or reset.
        end

        default: begin
          state_d   = ST_IDLE;
          cycle_d   = '0;
          instret_d = '0;
          hit_d     = '0;
          cap_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      instret_q <= '0;
      hit_q     <= '0;
      cap_q     <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      hit_q     <= hit_d;
      cap_q     <= cap_d;
      // Status flags are decoded from the next state so they line up
      // with state_q while still being driven straight from flops.
      pass_q    <= (state_d == ST_PASS);
      fail_q    <= (state_d == ST_FAIL);
      tmo_q     <= (state_d == ST_TMO);
      done_q    <= (state_d == ST_PASS) || (state_d == ST_FAIL) ||
                   (state_d == ST_TMO);
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign hit_cnt     = hit_q;
  assign result_cap  = cap_q;
  assign mon_state   = state_q;

endmodule

// File: tb/tb_test_end_monitor.sv
// tb/tb_test_end_monitor.sv - directed self-checking bench for test_end_monitor

module tb_test_end_monitor;

  logic        clk = 1'b0;
  logic        cpurst_n = 1'b0;
  logic        mon_en = 1'b0;
  logic        mon_clr = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] inst_pc = '0;
  logic [31:0] result_val = '0;

  // DUT A: timeout 100
  logic        a_done, a_pass, a_fail, a_tmo;
  logic [31:0] a_cyc, a_ins, a_hit, a_cap;
  logic [2:0]  a_st;
  // DUT B: timeout disabled
  logic        b_done, b_pass, b_fail, b_tmo;
  logic [31:0] b_cyc, b_ins, b_hit, b_cap;
  logic [2:0]  b_st;
  // DUT C: 4-bit counters, timeout disabled
  logic        c_done, c_pass, c_fail, c_tmo;
  logic [3:0]  c_cyc, c_ins, c_hit;
  logic [31:0] c_cap;
  logic [2:0]  c_st;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  test_end_monitor #(.TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .cpurst_n(cpurst_n), .mon_en(mon_en), .mon_clr(mon_clr),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .result_val(result_val),
    .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_tmo),
    .cycle_cnt(a_cyc), .instret_cnt(a_ins), .hit_cnt(a_hit),
    .result_cap(a_cap), .mon_state(a_st));

  test_end_monitor #(.TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .cpurst_n(cpurst_n), .mon_en(mon_en), .mon_clr(mon_clr),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .result_val(result_val),
    .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_tmo),
    .cycle_cnt(b_cyc), .instret_cnt(b_ins), .hit_cnt(b_hit),
    .result_cap(b_cap), .mon_state(b_st));

  test_end_monitor #(.CNT_W(4), .TIMEOUT_CYCLES(0)) dut_c (
    .clk(clk), .cpurst_n(cpurst_n), .mon_en(mon_en), .mon_clr(mon_clr),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .result_val(result_val),
    .done(c_done), .pass(c_pass), .fail(c_fail), .timeout(c_tmo),
    .cycle_cnt(c_cyc), .instret_cnt(c_ins), .hit_cnt(c_hit),
    .result_cap(c_cap), .mon_state(c_st));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clear all monitors, then enter RUN with counters at 0.
  task automatic start_run();
    mon_en = 1'b1;
    inst_valid = 1'b0;
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (a_st !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", a_st); end
    n_chk++; if ({a_done, a_pass, a_fail, a_tmo} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {a_done, a_pass, a_fail, a_tmo}); end
    n_chk++; if ({a_cyc, a_ins, a_hit, a_cap} !== 128'd0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {a_cyc, a_ins, a_hit, a_cap}); end
    @(negedge clk);
    cpurst_n = 1'b1;
    tick();
    n_chk++; if (a_st !== 3'd0) begin n_fail++; $display("FAIL idle_no_en got %0d exp 0", a_st); end
  endtask

  task automatic test_pass();
    start_run();
    n_chk++; if (a_st !== 3'd1 || a_cyc !== 32'd0) begin n_fail++; $display("FAIL pass_run_entry state %0d cyc %0d exp 1/0", a_st, a_cyc); end
    for (int i = 0; i < 28; i++) begin
      inst_valid = 1'b1;
      inst_pc = (i < 20) ? 32'h100 : 32'h86;
      result_val = 32'd1;
      if (i == 27) begin
        n_chk++; if (a_done !== 1'b0 || a_hit !== 32'd7) begin n_fail++; $display("FAIL pass_pre_final done %0d hit %0d exp 0/7", a_done, a_hit); end
      end
      tick();
    end
    inst_valid = 1'b0;
    n_chk++; if (a_done !== 1'b1 || a_pass !== 1'b1 || a_fail !== 1'b0) begin n_fail++; $display("FAIL pass_flags done %0d pass %0d fail %0d exp 1/1/0", a_done, a_pass, a_fail); end
    n_chk++; if (a_hit !== 32'd8) begin n_fail++; $display("FAIL pass_hit got %0d exp 8", a_hit); end
    n_chk++; if (a_ins !== 32'd28) begin n_fail++; $display("FAIL pass_instret got %0d exp 28", a_ins); end
    n_chk++; if (a_cyc !== 32'd28) begin n_fail++; $display("FAIL pass_cycle got %0d exp 28", a_cyc); end
    n_chk++; if (a_cap !== 32'd1 || a_st !== 3'd2) begin n_fail++; $display("FAIL pass_cap_state cap %0d st %0d exp 1/2", a_cap, a_st); end
    inst_valid = 1'b1;
    inst_pc = 32'h86;
    repeat (3) tick();
    inst_valid = 1'b0;
    n_chk++; if (a_hit !== 32'd8 || a_ins !== 32'd28 || a_cyc !== 32'd28) begin n_fail++; $display("FAIL pass_frozen hit %0d ins %0d cyc %0d exp 8/28/28", a_hit, a_ins, a_cyc); end
  endtask

  task automatic test_fail();
    start_run();
    for (int i = 0; i < 28; i++) begin
      inst_valid = 1'b1;
      inst_pc = (i < 20) ? 32'h100 : 32'h86;
      result_val = (i == 27) ? 32'd5 : 32'd1;
      tick();
    end
    inst_valid = 1'b0;
    n_chk++; if (a_fail !== 1'b1 || a_pass !== 1'b0 || a_done !== 1'b1) begin n_fail++; $display("FAIL fail_flags fail %0d pass %0d done %0d exp 1/0/1", a_fail, a_pass, a_done); end
    n_chk++; if (a_cap !== 32'd5 || a_st !== 3'd3) begin n_fail++; $display("FAIL fail_cap_state cap %0d st %0d exp 5/3", a_cap, a_st); end
    result_val = 32'd1;
    repeat (2) tick();
    n_chk++; if (a_cap !== 32'd5) begin n_fail++; $display("FAIL fail_cap_hold got %0d exp 5", a_cap); end
  endtask

  task automatic test_timeout();
    start_run();
    result_val = 32'h1234;
    inst_valid = 1'b0;
    repeat (99) tick();
    n_chk++; if (a_st !== 3'd1 || a_cyc !== 32'd99 || a_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_pre st %0d cyc %0d tmo %0d exp 1/99/0", a_st, a_cyc, a_tmo); end
    tick();
    n_chk++; if (a_tmo !== 1'b1 || a_done !== 1'b1 || a_pass !== 1'b0) begin n_fail++; $display("FAIL tmo_flags tmo %0d done %0d pass %0d exp 1/1/0", a_tmo, a_done, a_pass); end
    n_chk++; if (a_cyc !== 32'd100 || a_hit !== 32'd0 || a_st !== 3'd4) begin n_fail++; $display("FAIL tmo_state cyc %0d hit %0d st %0d exp 100/0/4", a_cyc, a_hit, a_st); end
    n_chk++; if (a_cap !== 32'h1234) begin n_fail++; $display("FAIL tmo_cap got %h exp 1234", a_cap); end
  endtask

  task automatic test_no_timeout();
    start_run();
    inst_valid = 1'b0;
    repeat (10000) tick();
    n_chk++; if (b_st !== 3'd1 || b_done !== 1'b0 || b_tmo !== 1'b0) begin n_fail++; $display("FAIL notmo_state st %0d done %0d tmo %0d exp 1/0/0", b_st, b_done, b_tmo); end
    n_chk++; if (b_cyc !== 32'd10000) begin n_fail++; $display("FAIL notmo_cycle got %0d exp 10000", b_cyc); end
  endtask

  task automatic test_hit_vs_timeout();
    start_run();
    result_val = 32'd1;
    inst_pc = 32'h86;
    for (int i = 0; i < 100; i++) begin
      inst_valid = (i >= 92);
      tick();
    end
    inst_valid = 1'b0;
    n_chk++; if (a_pass !== 1'b1 || a_tmo !== 1'b0 || a_st !== 3'd2) begin n_fail++; $display("FAIL race_flags pass %0d tmo %0d st %0d exp 1/0/2", a_pass, a_tmo, a_st); end
    n_chk++; if (a_cyc !== 32'd100 || a_hit !== 32'd8) begin n_fail++; $display("FAIL race_counts cyc %0d hit %0d exp 100/8", a_cyc, a_hit); end
  endtask

  task automatic test_pause_and_invalid_pc();
    start_run();
    inst_valid = 1'b0;
    inst_pc = 32'h86;
    repeat (50) tick();
    n_chk++; if (a_hit !== 32'd0 || a_ins !== 32'd0 || a_cyc !== 32'd50) begin n_fail++; $display("FAIL invpc hit %0d ins %0d cyc %0d exp 0/0/50", a_hit, a_ins, a_cyc); end
    mon_en = 1'b0;
    inst_valid = 1'b1;
    repeat (30) tick();
    n_chk++; if (a_cyc !== 32'd50 || a_hit !== 32'd0 || a_ins !== 32'd0 || a_st !== 3'd1) begin n_fail++; $display("FAIL pause cyc %0d hit %0d ins %0d st %0d exp 50/0/0/1", a_cyc, a_hit, a_ins, a_st); end
    mon_en = 1'b1;
    inst_valid = 1'b0;
    repeat (5) tick();
    n_chk++; if (a_cyc !== 32'd55) begin n_fail++; $display("FAIL resume cyc got %0d exp 55", a_cyc); end
  endtask

  task automatic test_async_reset_and_clear();
    start_run();
    inst_valid = 1'b1;
    inst_pc = 32'h100;
    repeat (10) tick();
    #3;
    cpurst_n = 1'b0;
    #1;
    n_chk++; if (a_st !== 3'd0 || a_cyc !== 32'd0 || a_ins !== 32'd0 || a_done !== 1'b0) begin n_fail++; $display("FAIL async_rst st %0d cyc %0d ins %0d done %0d exp 0", a_st, a_cyc, a_ins, a_done); end
    #10;
    cpurst_n = 1'b1;
    n_chk++; if (a_st !== 3'd0) begin n_fail++; $display("FAIL rst_release st %0d exp 0", a_st); end
    inst_valid = 1'b0;
    tick();
    n_chk++; if (a_st !== 3'd1 || a_cyc !== 32'd0) begin n_fail++; $display("FAIL rst_rerun st %0d cyc %0d exp 1/0", a_st, a_cyc); end
    result_val = 32'd1;
    inst_pc = 32'h86;
    inst_valid = 1'b1;
    repeat (8) tick();
    inst_valid = 1'b0;
    n_chk++; if (a_pass !== 1'b1) begin n_fail++; $display("FAIL clr_prepass pass %0d exp 1", a_pass); end
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
    n_chk++; if (a_st !== 3'd0 || a_hit !== 32'd0 || a_cyc !== 32'd0 || a_cap !== 32'd0 || a_done !== 1'b0 || a_pass !== 1'b0) begin n_fail++; $display("FAIL clr st %0d hit %0d cyc %0d cap %0d done %0d pass %0d exp 0", a_st, a_hit, a_cyc, a_cap, a_done, a_pass); end
    tick();
    inst_valid = 1'b1;
    repeat (8) tick();
    inst_valid = 1'b0;
    n_chk++; if (a_pass !== 1'b1 || a_hit !== 32'd8 || a_cyc !== 32'd8) begin n_fail++; $display("FAIL rerun_pass pass %0d hit %0d cyc %0d exp 1/8/8", a_pass, a_hit, a_cyc); end
  endtask

  task automatic test_saturation();
    start_run();
    inst_valid = 1'b1;
    inst_pc = 32'h100;
    repeat (20) tick();
    inst_valid = 1'b0;
    n_chk++; if (c_cyc !== 4'hF || c_ins !== 4'hF || c_st !== 3'd1) begin n_fail++; $display("FAIL sat cyc %0d ins %0d st %0d exp 15/15/1", c_cyc, c_ins, c_st); end
    n_chk++; if (a_cyc !== 32'd20 || a_ins !== 32'd20) begin n_fail++; $display("FAIL nosat cyc %0d ins %0d exp 20/20", a_cyc, a_ins); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_no_timeout();
    test_hit_vs_timeout();
    test_pause_and_invalid_pc();
    test_async_reset_and_clear();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
